// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background SECDED scrubber. Walks an inclusive address window,
// reads each word through the SEC checker, writes back single-bit corrections,
// counts corrected/uncorrectable errors and defers to host traffic on the port.
`timescale 1ns/1ps

module ecc_scrub_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16,
    parameter int IVL_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [IVL_W-1:0]  interval,
    input  logic              host_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [6:0]        mem_wparity,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic [6:0]        mem_rparity,
    output logic              sec_enable,
    output logic [31:0]       sec_data,
    output logic [6:0]        sec_parity,
    input  logic [31:0]       sec_corrected_data,
    input  logic [6:0]        sec_corrected_parity,
    input  logic              sec_single_error,
    input  logic              sec_double_error,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WR_REQ,
        S_NEXT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_q;
    logic [IVL_W-1:0]  ivl_q;
    logic [IVL_W-1:0]  wait_cnt;
    logic              req_held;
    logic [31:0]       wr_data_q;
    logic [6:0]        wr_parity_q;

    assign busy        = (state != S_IDLE);
    assign mem_addr    = cur;
    assign mem_wdata   = wr_data_q;
    assign mem_wparity = wr_parity_q;

    // State register; reset also drops any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and port strobes; a request only starts while the host is idle,
    // but once raised it stays up until acknowledged.
    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        sec_enable = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (base_addr > last_addr) ? S_IDLE : S_RD_REQ;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (wait_cnt == '0) begin
                    state_n = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                mem_req = req_held || !host_busy;
                if (mem_req && mem_ack) begin
                    state_n = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                sec_enable = 1'b1;
                if (sec_double_error || !sec_single_error) begin
                    state_n = S_NEXT;
                end else begin
                    state_n = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                mem_req = req_held || !host_busy;
                mem_we  = 1'b1;
                if (mem_req && mem_ack) begin
                    state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (stop || cur == last_q) begin
                    state_n = S_IDLE;
                end else if (ivl_q != '0) begin
                    state_n = S_WAIT;
                end else begin
                    state_n = S_RD_REQ;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Datapath: window capture, read capture, error logging, address walk and pacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= '0;
            last_q       <= '0;
            ivl_q        <= '0;
            wait_cnt     <= '0;
            req_held     <= 1'b0;
            sec_data     <= '0;
            sec_parity   <= '0;
            wr_data_q    <= '0;
            wr_parity_q  <= '0;
            corr_count   <= '0;
            uncorr_count <= '0;
            err_valid    <= 1'b0;
            err_addr     <= '0;
            done         <= 1'b0;
        end else begin
            done      <= 1'b0;
            err_valid <= 1'b0;
            req_held  <= mem_req && !mem_ack;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur          <= base_addr;
                        last_q       <= last_addr;
                        ivl_q        <= interval;
                        corr_count   <= '0;
                        uncorr_count <= '0;
                        done         <= (base_addr > last_addr);
                    end
                end
                S_WAIT: begin
                    if (!stop && wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - IVL_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        sec_data   <= mem_rdata;
                        sec_parity <= mem_rparity;
                    end
                end
                S_CHECK: begin
                    if (sec_double_error) begin
                        if (uncorr_count != '1) begin
                            uncorr_count <= uncorr_count + CNT_W'(1);
                        end
                        err_valid <= 1'b1;
                        err_addr  <= cur;
                    end else if (sec_single_error) begin
                        if (corr_count != '1) begin
                            corr_count <= corr_count + CNT_W'(1);
                        end
                        err_valid   <= 1'b1;
                        err_addr    <= cur;
                        wr_data_q   <= sec_corrected_data;
                        wr_parity_q <= sec_corrected_parity;
                    end
                end
                S_NEXT: begin
                    if (!stop) begin
                        if (cur == last_q) begin
                            done <= 1'b1;
                        end else begin
                            cur      <= cur + ADDR_W'(1);
                            wait_cnt <= ivl_q - IVL_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
